// File: rtl/sa_pkg.sv
// Shared defaults and FSM state encoding for the output-buffer reader slice.
package sa_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ob_mem.sv
// Output buffer storage: flop array, per-entry pending bits, sticky overflow.
// OUTPUT_BUFFER_BYPASS_EN lets a same-cycle write to a non-pending entry feed the read port.
module ob_mem
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_clr_overflow,
  output logic              o_rd_avail,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pending_nxt;
  logic              r_overflow;
  logic              w_collide;
  logic              w_ovf_set;
  logic              w_bypass_hit;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign w_collide = i_wr_en && i_fetch && (i_wr_addr == i_rd_addr);
  assign w_ovf_set = i_wr_en && r_pending[i_wr_addr] && !w_collide;

  // A write racing a fetch of the same entry leaves pending as it was:
  // still set when new data replaced a pending entry, still clear when bypassed.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_fetch) w_pending_nxt[i_rd_addr] = 1'b0;
    if (i_wr_en) w_pending_nxt[i_wr_addr] = w_collide ? r_pending[i_wr_addr] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_ovf_set)           r_overflow <= 1'b1;
      else if (i_clr_overflow) r_overflow <= 1'b0;
    end
  end

`ifdef OUTPUT_BUFFER_BYPASS_EN
  assign w_bypass_hit = i_wr_en && (i_wr_addr == i_rd_addr) && !r_pending[i_rd_addr];
`else
  assign w_bypass_hit = 1'b0;
`endif

  assign o_rd_avail = r_pending[i_rd_addr] || w_bypass_hit;
  assign o_rd_data  = w_bypass_hit ? i_wr_data : r_mem[i_rd_addr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/output_buffer_reader.sv
// Drains the accumulator output buffer as a valid/ready stream from a base address for a count.
// Optional OUTPUT_BUFFER_BYPASS_EN (in ob_mem) gives one-cycle write-to-beat latency.
module output_buffer_reader
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              output_buffer_enable,
  input  logic [ADDR_W-1:0] output_buffer_addr,
  input  logic [DATA_W-1:0] output_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_count,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  rd_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W:0]   r_remaining, w_remaining_nxt;
  logic              r_valid, w_valid_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              w_slot_free;
  logic              w_fetch;
  logic              w_avail;
  logic [DATA_W-1:0] w_mem_data;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > DEPTH_CNT) ? DEPTH_CNT : c;
  endfunction

  ob_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (output_buffer_enable),
    .i_wr_addr     (output_buffer_addr),
    .i_wr_data     (output_data),
    .i_fetch       (w_fetch),
    .i_rd_addr     (r_ptr),
    .i_clr_overflow(clr_overflow),
    .o_rd_avail    (w_avail),
    .o_rd_data     (w_mem_data),
    .o_overflow    (overflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RD_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_addr      <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_remaining_nxt = r_remaining;
    w_valid_nxt     = r_valid;
    w_data_nxt      = r_data;
    w_addr_nxt      = r_addr;
    w_fetch         = 1'b0;
    w_slot_free     = !r_valid || rd_ready;
    case (r_state)
      RD_IDLE: begin
        if (rd_start) begin
          w_ptr_nxt       = rd_base;
          w_remaining_nxt = clamp_count(rd_count);
          w_state_nxt     = RD_READ;
        end
      end
      RD_READ: begin
        // Stalls on a non-pending entry by simply not advancing the pointer.
        if (w_slot_free) begin
          if (r_remaining != '0) begin
            if (w_avail) begin
              w_fetch         = 1'b1;
              w_data_nxt      = w_mem_data;
              w_addr_nxt      = r_ptr;
              w_valid_nxt     = 1'b1;
              w_ptr_nxt       = r_ptr + ADDR_W'(1);
              w_remaining_nxt = r_remaining - (ADDR_W + 1)'(1);
            end else begin
              w_valid_nxt = 1'b0;
            end
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = RD_DONE;
          end
        end
      end
      RD_DONE: w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  assign rd_valid = r_valid;
  assign rd_data  = r_data;
  assign rd_addr  = r_addr;
  assign busy     = (r_state != RD_IDLE);
  assign done     = (r_state == RD_DONE);

endmodule

// File: tb/tb_output_buffer_reader.sv
// Directed-plus-random bench for output_buffer_reader against an array/queue reference model.
module tb_output_buffer_reader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          output_buffer_enable;
  logic [AW-1:0] output_buffer_addr;
  logic [DW-1:0] output_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_count;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          clr_overflow;

  output_buffer_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .output_buffer_enable(output_buffer_enable),
    .output_buffer_addr  (output_buffer_addr),
    .output_data         (output_data),
    .rd_start            (rd_start),
    .rd_base             (rd_base),
    .rd_count            (rd_count),
    .rd_ready            (rd_ready),
    .rd_valid            (rd_valid),
    .rd_data             (rd_data),
    .rd_addr             (rd_addr),
    .busy                (busy),
    .done                (done),
    .overflow            (overflow),
    .clr_overflow        (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } beat_t;

  beat_t         got[$];
  beat_t         exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  bit            pend_m [DEPTH];
  bit            ovf_m;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            done_cnt = 0;
  int            valid_cnt = 0;
  int            stab_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [AW-1:0] prev_a;

  // Handshake monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (done) done_cnt++;
      if (rd_valid) valid_cnt++;
      if (prev_stall && (!rd_valid || rd_data !== prev_d || rd_addr !== prev_a)) stab_err++;
      prev_stall = rd_valid && !rd_ready;
      prev_d     = rd_data;
      prev_a     = rd_addr;
      if (rd_valid && rd_ready) got.push_back('{rd_addr, rd_data, cyc});
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEPTH-1:0] pend_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = pend_m[i];
    return v;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    output_buffer_enable = 1'b1;
    output_buffer_addr   = a;
    output_data          = d;
    tick();
    output_buffer_enable = 1'b0;
    if (pend_m[a]) ovf_m = 1'b1;
    mem_m[a]  = d;
    pend_m[a] = 1'b1;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW:0] cnt);
    rd_base  = base;
    rd_count = cnt;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  // Expected drain: consecutive addresses (mod DEPTH) with whatever the model holds.
  task automatic build_exp(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + AW'(k);
      exp_q.push_back('{a, mem_m[a], 0});
      pend_m[a] = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, (done_cnt != d0), 1);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got[i].a, exp_q[i].a);
      check($sformatf("%s_data%0d", tag, i), got[i].d, exp_q[i].d);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    ovf_m = 1'b0;
  endtask

  initial begin
    int            d0;
    int            gap;
    int            v0;
    logic [DW-1:0] dnew;
    logic [DW-1:0] dold;
    bit            pat [4];

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0;
    output_buffer_enable = 1'b0;
    output_buffer_addr   = '0;
    output_data          = '0;
    rd_start     = 1'b0;
    rd_base      = '0;
    rd_count     = '0;
    rd_ready     = 1'b1;
    clr_overflow = 1'b0;
    ovf_m        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_m[i] = 1'b0;
      mem_m[i]  = '0;
    end

    // Reset state
    tick();
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pending", dut.u_mem.r_pending, pend_vec());
    rst = 1'b1;
    tick();

    // Pending-entry drain
    for (int i = 0; i < 4; i++) wr(AW'(2 + i), DW'(32'hA + i));
    build_exp(2, 4);
    d0 = done_cnt;
    start(2, 4);
    check("drain_busy", busy, 1);
    check("drain_valid_early", rd_valid, 0);
    tick();
    check("drain_first_valid", rd_valid, 1);
    check("drain_first_addr", rd_addr, 2);
    check("drain_first_data", rd_data, 32'hA);
    wait_done("drain_timeout", d0, 40);
    tick();
    tick();
    check("drain_done_once", done_cnt - d0, 1);
    gap = (got.size() == 4) ? (got[3].c - got[0].c) : -1;
    check("drain_back_to_back", gap, 3);
    compare_beats("drain");
    check("drain_pending", dut.u_mem.r_pending, pend_vec());

    // Wrap and stall
    wr(14, $urandom);
    wr(15, $urandom);
    wr(0, $urandom);
    d0 = done_cnt;
    start(14, 4);
    for (int i = 0; i < 5; i++) tick();
    check("stall_gap_valid", rd_valid, 0);
    check("stall_busy", busy, 1);
    wr(1, $urandom);
    build_exp(14, 4);
    wait_done("stall_timeout", d0, 40);
    gap = (got.size() == 4) ? (got[3].c - got[2].c) : 0;
    check("stall_has_gap", (gap > 1), 1);
    compare_beats("wrap");

    // Backpressure
    for (int i = 0; i < 4; i++) wr(AW'(8 + i), $urandom);
    build_exp(8, 4);
    stab_err = 0;
    d0 = done_cnt;
    start(8, 4);
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      rd_ready = pat[i % 4];
      tick();
    end
    rd_ready = 1'b1;
    check("bp_timeout", (done_cnt != d0), 1);
    tick();
    tick();
    check("bp_stable", stab_err, 0);
    check("bp_done_once", done_cnt - d0, 1);
    compare_beats("bp");

    // Overflow, sticky, clear, set-wins
    check("ovf_clear_before", overflow, ovf_m);
    wr(7, $urandom);
    wr(7, $urandom);
    check("ovf_set", overflow, ovf_m);
    build_exp(7, 1);
    d0 = done_cnt;
    start(7, 1);
    wait_done("ovf_rd_timeout", d0, 20);
    compare_beats("ovf_retained");
    check("ovf_sticky", overflow, ovf_m);
    pulse_clr();
    check("ovf_cleared", overflow, ovf_m);
    wr(7, $urandom);
    clr_overflow = 1'b1;
    wr(7, $urandom);
    clr_overflow = 1'b0;
    check("ovf_set_wins", overflow, ovf_m);
    build_exp(7, 1);
    d0 = done_cnt;
    start(7, 1);
    wait_done("ovf_rd2_timeout", d0, 20);
    compare_beats("ovf_second");
    pulse_clr();
    check("ovf_cleared2", overflow, ovf_m);

    // count = 0
    v0 = valid_cnt;
    d0 = done_cnt;
    start(0, 0);
    check("c0_busy", busy, 1);
    check("c0_done_early", done, 0);
    tick();
    check("c0_done", done, 1);
    check("c0_valid", rd_valid, 0);
    tick();
    check("c0_done_drop", done, 0);
    check("c0_idle", busy, 0);
    check("c0_no_beats", valid_cnt - v0, 0);
    check("c0_done_once", done_cnt - d0, 1);

    // count = 20 clamps to 16; rd_start while busy ignored
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom);
    check("c20_no_ovf", overflow, ovf_m);
    build_exp(5, 16);
    d0 = done_cnt;
    start(5, 20);
    tick();
    tick();
    start(0, 1);
    wait_done("c20_timeout", d0, 80);
    tick();
    tick();
    check("c20_idle", busy, 0);
    check("c20_done_once", done_cnt - d0, 1);
    compare_beats("c20");
    check("c20_pending", dut.u_mem.r_pending, pend_vec());

    // Same-cycle fetch and write to a pending entry
    dold = $urandom;
    dnew = $urandom;
    wr(3, dold);
    build_exp(3, 1);
    d0 = done_cnt;
    rd_base  = 3;
    rd_count = 1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    output_buffer_enable = 1'b1;
    output_buffer_addr   = 3;
    output_data          = dnew;
    tick();
    output_buffer_enable = 1'b0;
    mem_m[3]  = dnew;
    pend_m[3] = 1'b1;
    check("col_valid", rd_valid, 1);
    check("col_old_data", rd_data, dold);
    check("col_no_ovf", overflow, ovf_m);
    wait_done("col_timeout", d0, 20);
    compare_beats("col");
    check("col_pending", dut.u_mem.r_pending, pend_vec());
    build_exp(3, 1);
    d0 = done_cnt;
    start(3, 1);
    wait_done("col2_timeout", d0, 20);
    compare_beats("col_new");

    // Write to a non-pending ptr while the reader waits on it
    dnew = $urandom;
    d0 = done_cnt;
    start(6, 1);
    tick();
    tick();
    check("wait_valid", rd_valid, 0);
    output_buffer_enable = 1'b1;
    output_buffer_addr   = 6;
    output_data          = dnew;
    tick();
    output_buffer_enable = 1'b0;
    mem_m[6] = dnew;
`ifdef OUTPUT_BUFFER_BYPASS_EN
    check("byp_valid_1cyc", rd_valid, 1);
    check("byp_data", rd_data, dnew);
`else
    check("nobyp_valid_not_yet", rd_valid, 0);
    tick();
    check("nobyp_valid_2cyc", rd_valid, 1);
    check("nobyp_data", rd_data, dnew);
`endif
    exp_q.push_back('{AW'(6), dnew, 0});
    pend_m[6] = 1'b0;
    wait_done("late_wr_timeout", d0, 20);
    compare_beats("late_wr");
    check("late_wr_pending", dut.u_mem.r_pending, pend_vec());

    // Reset mid-stream
    for (int i = 0; i < 4; i++) wr(AW'(i), $urandom);
    wr(0, $urandom);
    check("mid_ovf_pre", overflow, ovf_m);
    rd_ready = 1'b0;
    start(0, 4);
    tick();
    tick();
    check("mid_valid_pre", rd_valid, 1);
    d0 = done_cnt;
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) pend_m[i] = 1'b0;
    ovf_m = 1'b0;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_addr", rd_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", overflow, ovf_m);
    check("mid_rst_pending", dut.u_mem.r_pending, pend_vec());
    tick();
    rst = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_idle", busy, 0);
    check("mid_valid_after", rd_valid, 0);
    got.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_buffer_reader.md
Name: output_buffer_reader

Overview:
- Receiving end of the accumulator's output-buffer write interface: a 16-entry x 32-bit buffer with per-entry pending bits.
- Drains stored results to the host/DMA side as a valid/ready stream, starting from a programmed base address for a programmed count.
- Sits between the accumulator and the host read path; it is the only consumer of output_data/output_buffer_addr/output_buffer_enable.

Parameters:
DATA_W, 32, width of one buffer entry (matches accumulator output_data)
ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W = 16 entries

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
output_buffer_enable  in  1  write strobe from accumulator
output_buffer_addr  in  ADDR_W  write address
output_data  in  DATA_W  write data
rd_start  in  1  one-cycle pulse: begin a drain transaction (sampled only in IDLE)
rd_base  in  ADDR_W  first address to read, sampled with rd_start
rd_count  in  ADDR_W+1  number of entries to read, 0..16; values >16 clamp to 16
rd_ready  in  1  host ready
rd_valid  out  1  rd_data/rd_addr hold a valid beat
rd_data  out  DATA_W  beat data
rd_addr  out  ADDR_W  buffer address the beat came from
busy  out  1  high in READ and DONE states
done  out  1  one-cycle pulse when the last beat has been accepted
overflow  out  1  sticky: a write hit an entry still pending
clr_overflow  in  1  clears overflow (synchronous)

Behaviour:
- Reset (rst=0, async): rd_valid=0, rd_data=0, rd_addr=0, busy=0, done=0, overflow=0, all pending bits=0, FSM=IDLE. Memory array is not reset. Reset mid-transaction aborts it without a done pulse.
- Write port: on output_buffer_enable, mem[addr]<=output_data and pending[addr]<=1. If pending[addr] was already 1 and the entry is not being read that same cycle, overflow<=1. Writes are accepted in every state.
- FSM states: IDLE, READ, DONE.
  - IDLE: on rd_start, latch ptr<=rd_base and remaining<=clamped rd_count, then go to READ. busy rises the next cycle.
  - READ: the output slot is free when rd_valid=0 or rd_ready=1. A fetch fires when the slot is free, remaining>0 and pending[ptr]=1. On a fetch: rd_data<=mem[ptr], rd_addr<=ptr, rd_valid<=1, pending[ptr]<=0, ptr<=ptr+1 (wraps 15->0), remaining--. If the slot is consumed and no fetch fires, rd_valid<=0. Stall on a non-pending entry by holding ptr.
  - READ exits to DONE when remaining=0 and the slot is free. rd_valid drops that cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- rd_count=0: READ->DONE immediately, no beats. done pulses 2 cycles after rd_start.
- rd_start while busy: ignored.
- Same-cycle write and fetch to the same pending entry: the fetch takes the old data. New data remains pending (pending stays 1). No overflow.
- Latency: pending entry at rd_base -> first rd_valid 2 cycles after rd_start. Back-to-back beats at 1/cycle with rd_ready held high.
- rd_data/rd_addr stay stable while rd_valid=1 and rd_ready=0.
- clr_overflow and a new overflow event in the same cycle: overflow stays 1 (set wins).

Optional Feature:
- Macro OUTPUT_BUFFER_BYPASS_EN.
- Defined: a write to ptr in the same cycle counts as pending for the fetch when pending[ptr]=0. rd_data takes output_data directly, and pending[ptr] stays 0. Write-to-beat latency is 1 cycle.
- Not defined: a fetch requires pending[ptr] already 1. Write-to-beat latency is 2 cycles.
- The pending-entry collision rule above is identical in both builds.

Decomposition:
- Shared package sa_pkg: DATA_W and ADDR_W defaults, DEPTH, and the FSM state enum/localparams (RD_IDLE, RD_READ, RD_DONE).
- One sub-module: ob_mem, the 16x32 flop array with a write port, a combinational read port and the pending-bit vector (set/clear/collision logic). The FSM and stream output live in the top.

Test Plan:
- Pending-entry drain: write 0xA..0xD to addr 2..5, then rd_start base=2 count=4 with rd_ready=1 -> beats (2,0xA),(3,0xB),(4,0xC),(5,0xD) on consecutive cycles; done pulses once; pending[2..5]=0 afterwards.
- Wrap and stall: base=14, count=4, entries 14,15,0 pending and entry 1 written 5 cycles later -> beats from addr 14,15,0, a gap, then addr 1. rd_valid stays low during the gap.
- Backpressure: rd_ready toggles 1,0,0,1 -> rd_data/rd_addr held stable while stalled; no beat lost or duplicated.
- Overflow: write addr 7 twice with no read between -> overflow=1 and second data retained. Pulse clr_overflow -> overflow=0.
- Boundaries: count=0 -> done only, no rd_valid. count=20 -> exactly 16 beats. rd_start while busy -> ignored.
- Reset and collision: assert rst mid-stream -> all outputs 0 and no done pulse. Fetch and write to the same pending addr 3 in one cycle -> old data out, new data read on the next transaction, overflow=0. Under OUTPUT_BUFFER_BYPASS_EN, a write to a non-pending ptr -> beat the next cycle.
